// File: rtl/dma_multichannel_datapath.sv
`default_nettype none
// ============================================================================
// Module      : dma_multichannel_datapath
// Description : Multi-channel DMA controller. Each channel holds base and
//               current copies of two addresses and a transfer count, plus a
//               mode register and a terminal-count flag. A round-robin arbiter
//               picks one requesting channel. The engine then runs one
//               read-then-write bus transfer per grant and updates that
//               channel's registers.
// Ports       : CLK, RESET_N           clock, async active-low reset
//               prog_*                 CPU register interface
//                                      (addr = {channel, reg[2:0]})
//               dreq / dack / tc       per-channel request, grant and
//                                      terminal-count pulse
//               bus_*                  system bus master (read/write strobes,
//                                      address, data, ready)
// Revision    : 1.0  initial release
// ============================================================================
module dma_multichannel_datapath #(
    parameter int NCH    = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    localparam int CHW   = $clog2(NCH),
    localparam int PAW   = CHW + 3,
    localparam int PW    = (ADDR_W > CNT_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                            : ((CNT_W > 8) ? CNT_W : 8)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              prog_en,
    input  logic              prog_wr,
    input  logic              prog_rd,
    input  logic [PAW-1:0]    prog_addr,
    input  logic [PW-1:0]     prog_wdata,
    output logic [PW-1:0]     prog_rdata,
    output logic              prog_ready,
    input  logic [NCH-1:0]    dreq,
    output logic [NCH-1:0]    dack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    output logic [NCH-1:0]    tc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_TYPE_IO2MEM = 2'b00;
    localparam logic [1:0] c_TYPE_M2M    = 2'b10;
    localparam logic [1:0] c_TYPE_RSVD   = 2'b11;

    // Per-channel register file
    logic [ADDR_W-1:0] r_baseA0 [NCH];
    logic [ADDR_W-1:0] r_curA0  [NCH];
    logic [ADDR_W-1:0] r_baseA1 [NCH];
    logic [ADDR_W-1:0] r_curA1  [NCH];
    logic [CNT_W-1:0]  r_baseCnt[NCH];
    logic [CNT_W-1:0]  r_curCnt [NCH];
    logic [4:0]        r_mode   [NCH];   // [4] en, [3] dec, [2] autoinit, [1:0] type
    logic [NCH-1:0]    r_tcFlag;

    // Engine state
    state_t            r_state;
    state_t            w_nextState;
    logic [CHW-1:0]    r_ch;
    logic [CHW-1:0]    r_lastServed;
    logic [NCH-1:0]    r_dack;
    logic [DATA_W-1:0] r_hold;
    logic [PW-1:0]     r_rdata;

    // Programming decode
    logic [CHW-1:0]    w_progCh;
    logic [2:0]        w_progReg;
    logic              w_progChOk;
    logic [PW-1:0]     w_rdVal;

    // Arbiter
    logic [NCH-1:0]    w_elig;
    logic              w_grantValid;
    logic [CHW-1:0]    w_grantCh;

    // Selected-channel view
    logic [4:0]        w_selMode;
    logic [ADDR_W-1:0] w_selA0;
    logic [ADDR_W-1:0] w_selA1;
    logic [CNT_W-1:0]  w_selCnt;
    logic              w_lastXfer;
    logic [ADDR_W-1:0] w_nextA0;
    logic [ADDR_W-1:0] w_nextA1;
    logic [ADDR_W-1:0] w_srcAddr;
    logic [ADDR_W-1:0] w_dstAddr;

    assign w_progCh   = prog_addr[PAW-1:3];
    assign w_progReg  = prog_addr[2:0];
    assign w_progChOk = (int'(w_progCh) < NCH);

    assign w_selMode  = r_mode[r_ch];
    assign w_selA0    = r_curA0[r_ch];
    assign w_selA1    = r_curA1[r_ch];
    assign w_selCnt   = r_curCnt[r_ch];
    assign w_lastXfer = (w_selCnt == '0);

    // Both addresses share one step direction; wrap is silent
    assign w_nextA0 = w_selMode[3] ? (w_selA0 - ADDR_W'(1)) : (w_selA0 + ADDR_W'(1));
    assign w_nextA1 = w_selMode[3] ? (w_selA1 - ADDR_W'(1)) : (w_selA1 + ADDR_W'(1));

    // io_to_mem reads the fixed addr1 and writes addr0; the other types read addr0
    assign w_srcAddr = (w_selMode[1:0] == c_TYPE_IO2MEM) ? w_selA1 : w_selA0;
    assign w_dstAddr = (w_selMode[1:0] == c_TYPE_IO2MEM) ? w_selA0 : w_selA1;

    assign prog_ready = (r_state == S_IDLE);
    assign prog_rdata = r_rdata;
    assign dack       = r_dack;
    assign bus_wdata  = r_hold;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
        assign w_elig[gi] = dreq[gi] & r_mode[gi][4] & (r_mode[gi][1:0] != c_TYPE_RSVD);
    end

    // Round-robin: scan from the farthest offset down so the channel nearest
    // to last_served+1 is the one left standing.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantCh    = '0;
        for (int i = NCH; i >= 1; i--) begin
            if (w_elig[(int'(r_lastServed) + i) % NCH]) begin
                w_grantValid = 1'b1;
                w_grantCh    = CHW'((int'(r_lastServed) + i) % NCH);
            end
        end
    end

    always_comb begin
        w_rdVal = '0;
        if (w_progChOk) begin
            case (w_progReg)
                3'd0:    w_rdVal[ADDR_W-1:0] = r_curA0[w_progCh];
                3'd1:    w_rdVal[ADDR_W-1:0] = r_curA1[w_progCh];
                3'd2:    w_rdVal[CNT_W-1:0]  = r_curCnt[w_progCh];
                3'd3:    w_rdVal[4:0]        = r_mode[w_progCh];
                3'd4:    w_rdVal[1:0]        = {r_mode[w_progCh][4], r_tcFlag[w_progCh]};
                default: w_rdVal             = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        bus_rd      = 1'b0;
        bus_wr      = 1'b0;
        bus_addr    = '0;
        tc          = '0;
        case (r_state)
            S_IDLE: begin
                if (!prog_en && w_grantValid) begin
                    w_nextState = S_READ;
                end
            end
            S_READ: begin
                bus_rd   = 1'b1;
                bus_addr = w_srcAddr;
                if (bus_ready) begin
                    w_nextState = S_WRITE;
                end
            end
            S_WRITE: begin
                bus_wr   = 1'b1;
                bus_addr = w_dstAddr;
                if (bus_ready) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                if (w_lastXfer) begin
                    tc = NCH'(1) << r_ch;
                end
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NCH; i++) begin
                r_baseA0[i]  <= '0;
                r_curA0[i]   <= '0;
                r_baseA1[i]  <= '0;
                r_curA1[i]   <= '0;
                r_baseCnt[i] <= '0;
                r_curCnt[i]  <= '0;
                r_mode[i]    <= '0;
            end
            r_tcFlag     <= '0;
            r_ch         <= '0;
            r_lastServed <= CHW'(NCH - 1);
            r_dack       <= '0;
            r_hold       <= '0;
            r_rdata      <= '0;
        end else begin
            // CPU access is only honoured while the engine is idle
            if (r_state == S_IDLE && w_progChOk) begin
                if (prog_wr) begin
                    case (w_progReg)
                        3'd0: begin
                            r_baseA0[w_progCh] <= prog_wdata[ADDR_W-1:0];
                            r_curA0[w_progCh]  <= prog_wdata[ADDR_W-1:0];
                        end
                        3'd1: begin
                            r_baseA1[w_progCh] <= prog_wdata[ADDR_W-1:0];
                            r_curA1[w_progCh]  <= prog_wdata[ADDR_W-1:0];
                        end
                        3'd2: begin
                            r_baseCnt[w_progCh] <= prog_wdata[CNT_W-1:0];
                            r_curCnt[w_progCh]  <= prog_wdata[CNT_W-1:0];
                        end
                        3'd3:    r_mode[w_progCh] <= prog_wdata[4:0];
                        default: ;
                    endcase
                end
                if (prog_rd && w_progReg == 3'd4) begin
                    r_tcFlag[w_progCh] <= 1'b0;
                end
            end
            if (r_state == S_IDLE && prog_rd) begin
                r_rdata <= w_rdVal;
            end

            if (r_state == S_IDLE && w_nextState == S_READ) begin
                r_ch   <= w_grantCh;
                r_dack <= NCH'(1) << w_grantCh;
            end

            if (r_state == S_READ && bus_ready) begin
                r_hold <= bus_rdata;
            end

            if (r_state == S_DONE) begin
                r_lastServed <= r_ch;
                r_dack       <= '0;
                if (w_lastXfer && w_selMode[2]) begin
                    r_curA0[r_ch]  <= r_baseA0[r_ch];
                    r_curA1[r_ch]  <= r_baseA1[r_ch];
                    r_curCnt[r_ch] <= r_baseCnt[r_ch];
                end else begin
                    r_curA0[r_ch]  <= w_nextA0;
                    if (w_selMode[1:0] == c_TYPE_M2M) begin
                        r_curA1[r_ch] <= w_nextA1;
                    end
                    r_curCnt[r_ch] <= w_selCnt - CNT_W'(1);
                    if (w_lastXfer) begin
                        r_mode[r_ch][4] <= 1'b0;
                    end
                end
                if (w_lastXfer) begin
                    r_tcFlag[r_ch] <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
